fifo_read_ctrl: RTL and testbench

//   Read-side pointer/flag controller of the dual-clock async FIFO, entirely in the clk_d domain.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/cdc_sync_bus.sv | 41 ++++
 rtl/fifo_read_ctrl.sv | 93 +++++++++
 tb/tb_fifo_read_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Pointer geometry and Gray-code helpers shared by the read-side and
//   write-side controllers of the dual-clock FIFO.
//   FIFO_ADDR_W : storage address bits (depth = 2**FIFO_ADDR_W)
//   FIFO_PTR_W  : pointer width, one extra bit to tell laps apart
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ADDR_W = 3;
    localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;

    function automatic logic [FIFO_PTR_W-1:0] bin2gray(input logic [FIFO_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [FIFO_PTR_W-1:0] gray2bin(input logic [FIFO_PTR_W-1:0] gray);
        logic [FIFO_PTR_W-1:0] bin;
        bin[FIFO_PTR_W-1] = gray[FIFO_PTR_W-1];
        for (int i = FIFO_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// ---------------------------------------------------------------------------
// cdc_sync_bus
//   Plain multi-stage flop chain that brings a Gray-coded bus into the local
//   clock domain. No logic sits between stages.
//   Ports:
//     clk  in   local clock
//     rst  in   synchronous active-high reset, clears every stage
//     d    in   WIDTH  asynchronous input bus
//     q    out  WIDTH  synchronised copy (last stage)
//   Parameters: WIDTH bus width, STAGES flop stages (2..4)
// ---------------------------------------------------------------------------
module cdc_sync_bus #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_ff [STAGES];

    // NOTE: the chain is reset too so both sides restart from pointer 0;
    // otherwise a stale pointer could leak out for STAGES cycles after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_ff[i] <= '0;
            end
        end else begin
            sync_ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl
//   Read-side pointer/flag controller of the dual-clock FIFO (clk_d domain).
//   Synchronises the writer's Gray pointer, keeps the binary read counter,
//   drives the storage read address and derives a registered empty flag.
//   Ports:
//     clk_d         in   read-domain clock
//     rst           in   synchronous active-high reset
//     wr_ptr_gray   in   ADDR_W+1  Gray write pointer from the clk_s domain
//     rd_en         in   read request (ignored while empty)
//     read_pointer  out  ADDR_W    storage read address
//     rd_ptr_gray   out  ADDR_W+1  registered Gray read pointer to writer
//     empty         out  registered empty flag
//     dout_valid    out  storage dout holds a newly read word
//     rd_level      out  ADDR_W+1  readable-entry lower bound
//                        (only when FIFO_RD_LEVEL_EN is defined)
//   ADDR_W must match FIFO_ADDR_W, the helpers in fifo_pkg are sized by it.
// ---------------------------------------------------------------------------
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = FIFO_ADDR_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_d,
    input  logic              rst,
    input  logic [ADDR_W:0]   wr_ptr_gray,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] read_pointer,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic              empty,
    output logic              dout_valid
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDR_W:0]   rd_level
`endif
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] rd_bin;
    logic [PTR_W-1:0] next_bin;
    logic [PTR_W-1:0] next_gray;
    logic [PTR_W-1:0] wq_gray;
    logic             rd_acc;

    cdc_sync_bus #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .clk (clk_d),
        .rst (rst),
        .d   (wr_ptr_gray),
        .q   (wq_gray)
    );

    // NOTE: every signal driven here gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        rd_acc    = rd_en & ~empty;
        next_bin  = rd_bin + PTR_W'(rd_acc);
        next_gray = bin2gray(next_bin);
    end

    assign read_pointer = rd_bin[ADDR_W-1:0];

    // Empty compares against the post-increment pointer so the flag is
    // correct in the cycle after the last word is taken. Because wq_gray
    // lags the writer, the flag is pessimistic but never optimistic.
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk_d) begin
        if (rst) begin
            rd_bin      <= '0;
            rd_ptr_gray <= '0;
            empty       <= 1'b1;
            dout_valid  <= 1'b0;
`ifdef FIFO_RD_LEVEL_EN
            rd_level    <= '0;
`endif
        end else begin
            rd_bin      <= next_bin;
            rd_ptr_gray <= next_gray;
            empty       <= (next_gray == wq_gray);
            dout_valid  <= rd_acc;
`ifdef FIFO_RD_LEVEL_EN
            // Wraps modulo 2**PTR_W, which is exactly the lap arithmetic.
            rd_level    <= gray2bin(wq_gray) - next_bin;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_read_ctrl
//   Directed bench for fifo_read_ctrl. A behavioural writer fills an 8-entry
//   array model and pushes each written word into a scoreboard queue; a
//   monitor pops and compares whenever dout_valid is high. Pointer and flag
//   values are checked against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fifo_read_ctrl;

    logic       clk_d = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] wr_ptr_gray = '0;
    logic       rd_en = 1'b0;
    logic [2:0] read_pointer;
    logic [3:0] rd_ptr_gray;
    logic       empty;
    logic       dout_valid;
`ifdef FIFO_RD_LEVEL_EN
    logic [3:0] rd_level;
`endif

    int total = 0;
    int bad   = 0;

    // Storage array model and writer state
    logic [7:0] mem [8];
    logic [7:0] dout;
    logic [3:0] wr_bin = '0;
    logic [7:0] exp_q [$];

    // Gray sequence 0..15, written out by hand
    logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};

    fifo_read_ctrl #(
        .ADDR_W      (3),
        .SYNC_STAGES (2)
    ) dut (
        .clk_d        (clk_d),
        .rst          (rst),
        .wr_ptr_gray  (wr_ptr_gray),
        .rd_en        (rd_en),
        .read_pointer (read_pointer),
        .rd_ptr_gray  (rd_ptr_gray),
        .empty        (empty),
        .dout_valid   (dout_valid)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .rd_level     (rd_level)
`endif
    );

    always #5 clk_d = ~clk_d;

    // Array registers dout from the current read address every edge.
    always @(posedge clk_d) dout <= mem[read_pointer];

    // Scoreboard monitor
    always @(negedge clk_d) begin
        if (dout_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_data: dout=%02h but no word expected", dout);
            end else begin
                logic [7:0] exp_word;
                exp_word = exp_q.pop_front();
                if (dout !== exp_word) begin
                    bad++;
                    $display("FAIL sb_data: got %02h expected %02h", dout, exp_word);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_d);
            #1;
        end
    endtask

    task automatic write_word(input logic [7:0] data);
        mem[wr_bin[2:0]] = data;
        wr_bin = wr_bin + 4'd1;
        wr_ptr_gray = wr_bin ^ (wr_bin >> 1);
        exp_q.push_back(data);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd_en = 1'b0;
        wr_bin = '0;
        wr_ptr_gray = '0;
        tick(1);
        exp_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;

        // 1. Reset held two cycles
        tick(2);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_rp", 32'(read_pointer), 32'd0);
        check("rst_gray", 32'(rd_ptr_gray), 32'd0);
        check("rst_dv", 32'(dout_valid), 32'd0);
        rst = 1'b0;

        // 2. One write: empty falls on the third edge, then one read
        write_word(8'h11);
        tick(1);
        check("t2_empty_e1", 32'(empty), 32'd1);
        tick(1);
        check("t2_empty_e2", 32'(empty), 32'd1);
        tick(1);
        check("t2_empty_e3", 32'(empty), 32'd0);
        rd_en = 1'b1;
        tick(1);
        check("t2_rp", 32'(read_pointer), 32'd1);
        check("t2_dv", 32'(dout_valid), 32'd1);
        check("t2_empty_after", 32'(empty), 32'd1);
        check("t2_gray", 32'(rd_ptr_gray), 32'b0001);

        // 3. rd_en held while empty
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t3_rp_hold", 32'(read_pointer), 32'd1);
            check("t3_dv_low", 32'(dout_valid), 32'd0);
        end
        rd_en = 1'b0;

        // 4. Eight words, eight back-to-back reads
        do_reset();
        for (int i = 0; i < 8; i++) write_word(8'hA0 + 8'(i));
        tick(3);
        check("t4_empty_fall", 32'(empty), 32'd0);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t4_rp_seq", 32'(read_pointer), 32'(i));
            tick(1);
            check("t4_dv_burst", 32'(dout_valid), 32'd1);
        end
        rd_en = 1'b0;
        check("t4_rp_wrap", 32'(read_pointer), 32'd0);
        check("t4_gray", 32'(rd_ptr_gray), 32'b1100);
        check("t4_empty", 32'(empty), 32'd1);
        tick(1);
        check("t4_dv_end", 32'(dout_valid), 32'd0);
        check("t4_sb_drained", 32'(exp_q.size()), 32'd0);

        // 5. Sixteen write/read pairs across the 15 -> 0 wrap
        begin
            int exp_rd;
            exp_rd = 8;
            for (int i = 0; i < 16; i++) begin
                write_word(8'h40 + 8'(i));
                tick(3);
                check("t5_empty_fall", 32'(empty), 32'd0);
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
                exp_rd = (exp_rd + 1) % 16;
                check("t5_rp", 32'(read_pointer), 32'(exp_rd % 8));
                check("t5_gray", 32'(rd_ptr_gray), 32'(gray_tab[exp_rd]));
                check("t5_empty", 32'(empty), 32'd1);
                check("t5_dv", 32'(dout_valid), 32'd1);
            end
        end
        tick(1);
        check("t5_sb_drained", 32'(exp_q.size()), 32'd0);

        // 6. Reset in the middle of a burst
        for (int i = 0; i < 8; i++) write_word(8'hC0 + 8'(i));
        tick(3);
        rd_en = 1'b1;
        tick(5);
        check("t6_rp_mid", 32'(read_pointer), 32'd5);
        rst = 1'b1;
        wr_bin = '0;
        wr_ptr_gray = '0;
        tick(1);
        exp_q.delete();
        check("t6_rst_rp", 32'(read_pointer), 32'd0);
        check("t6_rst_gray", 32'(rd_ptr_gray), 32'd0);
        check("t6_rst_empty", 32'(empty), 32'd1);
        check("t6_rst_dv", 32'(dout_valid), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
        check("t6_rst_level", 32'(rd_level), 32'd0);
`endif
        rd_en = 1'b0;
        rst = 1'b0;
        tick(3);
        check("t6_empty_stays", 32'(empty), 32'd1);

        // Level after six writes and two reads
        for (int i = 0; i < 6; i++) write_word(8'h70 + 8'(i));
        tick(3);
`ifdef FIFO_RD_LEVEL_EN
        check("t6_level6", 32'(rd_level), 32'd6);
`endif
        rd_en = 1'b1;
        tick(2);
        rd_en = 1'b0;
        check("t6_rp2", 32'(read_pointer), 32'd2);
`ifdef FIFO_RD_LEVEL_EN
        check("t6_level4", 32'(rd_level), 32'd4);
`endif
        rd_en = 1'b1;
        tick(4);
        rd_en = 1'b0;
        tick(2);
        check("t6_drain_empty", 32'(empty), 32'd1);
        check("t6_drain_rp", 32'(read_pointer), 32'd6);
        check("t6_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
